branch_compare_pipe: RTL
========================

Name: branch_compare_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle branch comparator in the 16-bit datapath.
- Compares operand_a (register-file read port 1) against operand_b (R15, or any register the decoder selects) under a decoded condition code.
- Adds signed/unsigned mode, six conditions, a valid/stall/flush pipeline and a saturating taken-branch counter.
- Sits between register read and PC-select logic; comp_out drives the branch mux.

Parameters:
- WIDTH, 16, operand width in bits (>=2).
- LATENCY, 1, cycles from accepted input to out_valid; legal values 1 or 2 only.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and ctrl are valid this cycle.
- ctrl  in  3  condition: 0 none, 1 LT, 2 GT, 3 EQ, 4 NE, 5 LE, 6 GE, 7 reserved (treated as none).
- signed_mode  in  1  1 = two's-complement compare; 0 = unsigned compare.
- operand_a  in  WIDTH  left operand (readData1).
- operand_b  in  WIDTH  right operand (R15).
- stall  in  1  hold every pipeline stage.
- flush  in  1  kill all in-flight compares.
- count_clr  in  1  clear taken_count.
- out_valid  out  1  comp_out is a valid result.
- comp_out  out  1  condition true (branch taken).
- taken_count  out  CNT_W  saturating count of taken results.

Behaviour:
- Reset: clk and rst are the only clock and reset. On the rst edge, all stage valid bits, out_valid, comp_out and taken_count go to 0. Operand registers may be left at any value but must never be observable.
- Condition evaluation: a op b, with op selected by ctrl.
  - signed_mode=1: compare as signed WIDTH-bit values. 0x8000 < 0x0001 at WIDTH=16.
  - signed_mode=0: compare as unsigned values.
  - ctrl 0 or 7: result 0, but the result still flows through the pipe with valid set.
  - No latches: every output is defined for every ctrl value.
- LATENCY=1: the result is registered directly. An input accepted at edge N appears on out_valid/comp_out after edge N.
- LATENCY=2: stage 1 registers operands, ctrl and signed_mode. Stage 2 registers the result. Output appears after edge N+1.
- Accept rule: input is accepted when in_valid=1, stall=0 and flush=0. in_valid during stall is ignored; upstream must hold its request.
- Stall:
  - All stage registers, out_valid, comp_out and taken_count hold their values.
  - A valid output stays asserted for as long as stall is held.
- Flush:
  - On the next edge, all stage valid bits and out_valid clear and comp_out becomes 0.
  - A same-cycle input is dropped.
  - Flush has priority over stall and over in_valid.
- Back-to-back: one compare is accepted per cycle with no bubbles. Throughput is 1/cycle at either latency.
- comp_out is forced to 0 whenever out_valid=0.
- taken_count:
  - Increments by 1 on each edge where a result with comp_out=1 is loaded into the output register (not stalled, not flushed). Each result counts once.
  - Saturates at 2^CNT_W-1.
  - count_clr=1 clears it to 0 on the next edge and has priority over the increment.
  - The counter is unaffected by flush, apart from the dropped results never being counted.
- Reset mid-operation: all in-flight compares are discarded and nothing is counted.

Test Plan:
- Unsigned/signed LT, LATENCY=1: a=0x8000, b=0x0001, ctrl=1.
  - signed_mode=0 -> out_valid=1, comp_out=0 one edge later.
  - signed_mode=1 -> comp_out=1.
- All conditions: a=b=0x1234, ctrl 1..6 back-to-back -> comp_out sequence 0,0,1,0,1,1 on consecutive cycles; taken_count=3.
- LATENCY=2 stall: issue GT with a=5, b=3, then assert stall for 3 cycles once out_valid=1.
  - out_valid=1 and comp_out=1 held for all 4 cycles.
  - taken_count increments exactly once.
- Flush: LATENCY=2, two EQ compares in flight (both true), flush=1 with stall=1 -> next cycle out_valid=0, comp_out=0, taken_count unchanged.
- Counter: CNT_W=4, 17 taken EQ results -> taken_count saturates at 15. count_clr together with a taken result -> taken_count=0.
- Reset mid-stream: rst=1 while a taken compare is in stage 1 -> next cycle out_valid=0, comp_out=0, taken_count=0, and nothing emerges afterward.

Source files
------------

// File: rtl/branch_compare_pipe.sv
// branch_compare_pipe: pipelined signed/unsigned branch comparator with a saturating taken-branch counter
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid            operands/ctrl valid (accepted when stall=0 and flush=0)
//   ctrl                0 none, 1 LT, 2 GT, 3 EQ, 4 NE, 5 LE, 6 GE, 7 none
//   signed_mode         1 = two's-complement compare, 0 = unsigned compare
//   operand_a/b         left/right operands
//   stall, flush        hold all stages / kill all in-flight compares (flush wins)
//   count_clr           clear taken_count (wins over increment)
//   out_valid, comp_out registered result, comp_out forced low when not valid
//   taken_count         saturating count of taken results
module branch_compare_pipe #(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [2:0]       ctrl,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             stall,
   input  logic             flush,
   input  logic             count_clr,
   output logic             out_valid,
   output logic             comp_out,
   output logic [CNT_W-1:0] taken_count
);
   logic             w_acc, w_v, w_sm, w_lt, w_eq, w_res;
   logic [2:0]       w_ctrl;
   logic [WIDTH-1:0] w_a, w_b;
   logic [7:0]       w_cond;
   logic             r_out_valid, r_comp;
   logic [CNT_W-1:0] r_cnt;
   assign w_acc = in_valid & ~stall & ~flush;
   generate
      if (LATENCY == 2) begin : g_s1
         logic             r_v, r_sm;
         logic [2:0]       r_ctrl;
         logic [WIDTH-1:0] r_a, r_b;
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               r_v <= 1'b0;
            end else if (!stall) begin
               r_v    <= w_acc;
               r_a    <= operand_a;
               r_b    <= operand_b;
               r_ctrl <= ctrl;
               r_sm   <= signed_mode;
            end
         end
         assign w_v    = r_v;
         assign w_a    = r_a;
         assign w_b    = r_b;
         assign w_ctrl = r_ctrl;
         assign w_sm   = r_sm;
      end else begin : g_s0
         assign w_v    = w_acc;
         assign w_a    = operand_a;
         assign w_b    = operand_b;
         assign w_ctrl = ctrl;
         assign w_sm   = signed_mode;
      end
   endgenerate
   assign w_lt   = w_sm ? ($signed(w_a) < $signed(w_b)) : (w_a < w_b);
   assign w_eq   = w_a == w_b;
   // one bit per condition code, indexed directly by ctrl; codes 0 and 7 read a constant 0
   assign w_cond = {1'b0, ~w_lt, w_lt | w_eq, ~w_eq, w_eq, ~w_lt & ~w_eq, w_lt, 1'b0};
   assign w_res  = w_cond[w_ctrl];
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_out_valid <= 1'b0;
         r_comp      <= 1'b0;
      end else if (!stall) begin
         r_out_valid <= w_v;
         r_comp      <= w_v & w_res;
      end
   end
   always_ff @(posedge clk) begin
      if (rst || count_clr)
         r_cnt <= '0;
      else if (!stall && !flush && w_v && w_res && r_cnt != '1)
         r_cnt <= r_cnt + 1'b1;
   end
   assign out_valid   = r_out_valid;
   assign comp_out    = r_comp;
   assign taken_count = r_cnt;
endmodule
